// File: rtl/rburst_counter_pkg.sv
// ---------------------------------------------------------------------------
// rburst_counter_pkg
// Shared definitions for the AXI read/write burst counters:
//   - FSM state encoding for the burst counters (3-bit)
//   - default burst-length field width and maximum beats per burst
// ---------------------------------------------------------------------------
package rburst_counter_pkg;

    typedef logic [2:0] rb_state_t;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ISSUE = 3'd1;
    localparam logic [2:0] READY = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Shared by the read and write burst counters: ARLEN/AWLEN-style field
    // width (beats-1) and the largest burst either side will request.
    localparam int BURST_LEN_W_DEFAULT   = 4;
    localparam int MAX_BURST_LEN_DEFAULT = 16;

endpackage

// File: rtl/rburst_credit.sv
// ---------------------------------------------------------------------------
// rburst_credit
// Read-buffer credit and outstanding-burst accounting.
//   clk, reset        clock, asynchronous active-high reset
//   issued/issued_len AR handshake and its length (beats-1)
//   rdata_last        R beat with RLAST (one burst retired)
//   buffer_pop        consumer removed one beat from the read FIFO
//   len               length (beats-1) of the burst about to be requested
//   credit_ok         buffer space for len+1 beats and an outstanding slot free
//   outstanding       bursts in flight; outstanding_next is next-cycle value
// ---------------------------------------------------------------------------
module rburst_credit #(
    parameter int RBURST_LEN      = 4,
    parameter int RBUF_DEPTH      = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     issued,
    input  logic [RBURST_LEN-1:0]                    issued_len,
    input  logic                                     rdata_last,
    input  logic                                     buffer_pop,
    input  logic [RBURST_LEN-1:0]                    len,
    output logic                                     credit_ok,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]     outstanding_next
);

    localparam int CREDIT_W = $clog2(RBUF_DEPTH + 1);
    localparam int SUM_W    = CREDIT_W + 1;
    localparam int OUT_W    = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [SUM_W-1:0] DEPTH_W = SUM_W'(RBUF_DEPTH);
    localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTSTANDING);

    logic [CREDIT_W-1:0] credit_reg, credit_next;
    logic [OUT_W-1:0]    outstanding_reg;
    logic [SUM_W-1:0]    credit_plus, issue_beats, credit_sum;

    // One extra bit so a pop at full credit is visible and can be clipped.
    assign credit_plus = {1'b0, credit_reg} + SUM_W'(buffer_pop);
    assign issue_beats = issued ? (SUM_W'(issued_len) + SUM_W'(1)) : '0;

    always_comb begin
        credit_sum = credit_plus - issue_beats;
        if (credit_plus < issue_beats) begin
            // Only reachable on an issuer protocol error; clamp instead of wrapping.
            credit_next = '0;
        end else if (credit_sum > DEPTH_W) begin
            credit_next = CREDIT_W'(RBUF_DEPTH);
        end else begin
            credit_next = CREDIT_W'(credit_sum);
        end
    end

    always_comb begin
        outstanding_next = outstanding_reg;
        if (issued && !rdata_last) begin
            if (outstanding_reg != '1) begin
                outstanding_next = outstanding_reg + OUT_W'(1);
            end
        end else if (!issued && rdata_last) begin
            if (outstanding_reg != '0) begin
                outstanding_next = outstanding_reg - OUT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_reg      <= CREDIT_W'(RBUF_DEPTH);
            outstanding_reg <= '0;
        end else begin
            credit_reg      <= credit_next;
            outstanding_reg <= outstanding_next;
        end
    end

    assign outstanding = outstanding_reg;
    assign credit_ok   = ({1'b0, credit_reg} >= (SUM_W'(len) + SUM_W'(1)))
                         && (outstanding_reg < OUT_MAX);

endmodule

// File: rtl/rburst_counter.sv
// ---------------------------------------------------------------------------
// rburst_counter
// Splits an N-beat read transfer into AR bursts of at most MAX_BURST_LEN
// beats, requesting each burst only when the read FIFO has room for all of
// its beats and the outstanding-burst limit allows another one.
//   clk, reset              clock, asynchronous active-high reset
//   rd_req/rd_req_beats     start a transfer (accepted in IDLE only)
//   rd_req_ready            high in IDLE
//   rburst_len/rburst_ready next burst length (beats-1) and request strobe
//   rburst_issued[_len]     AR handshake and the length actually issued
//   rdata_last              R beat with RLAST
//   buffer_pop              one beat left the read FIFO
//   outstanding             bursts in flight
//   rd_done                 one-cycle pulse when the transfer has completed
//   stall_count             cycles spent waiting in ISSUE for credit/slots
// Build option: define RBURST_STATS_EN to generate the stall counter;
// otherwise stall_count is constant zero.
// ---------------------------------------------------------------------------
module rburst_counter
    import rburst_counter_pkg::*;
#(
    parameter int TXN_LEN_W       = 16,
    parameter int RBURST_LEN      = BURST_LEN_W_DEFAULT,
    parameter int MAX_BURST_LEN   = MAX_BURST_LEN_DEFAULT,
    parameter int RBUF_DEPTH      = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 rd_req,
    input  logic [TXN_LEN_W-1:0]                 rd_req_beats,
    output logic                                 rd_req_ready,
    output logic [RBURST_LEN-1:0]                rburst_len,
    output logic                                 rburst_ready,
    input  logic                                 rburst_issued,
    input  logic [RBURST_LEN-1:0]                rburst_issued_len,
    input  logic                                 rdata_last,
    input  logic                                 buffer_pop,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
    output logic                                 rd_done,
    output logic [31:0]                          stall_count
);

    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    rb_state_t            state_reg, state_next;
    logic [TXN_LEN_W-1:0] remaining_reg, remaining_next;
    logic [TXN_LEN_W-1:0] issue_beats, rem_after;
    logic [OUT_W-1:0]     outstanding_next;
    logic                 credit_ok, burst_ok;

    always_comb begin
        if (remaining_reg >= TXN_LEN_W'(MAX_BURST_LEN)) begin
            rburst_len = RBURST_LEN'(MAX_BURST_LEN - 1);
        end else if (remaining_reg != '0) begin
            rburst_len = RBURST_LEN'(remaining_reg - TXN_LEN_W'(1));
        end else begin
            rburst_len = '0;
        end
    end

    assign issue_beats = TXN_LEN_W'({1'b0, rburst_issued_len}) + TXN_LEN_W'(1);
    assign rem_after   = remaining_reg - issue_beats;
    assign burst_ok    = (remaining_reg != '0) && credit_ok;

    // Credit and outstanding track every AR handshake, even one that arrives
    // outside READY, so the buffer reservation always matches the bus.
    rburst_credit #(
        .RBURST_LEN      (RBURST_LEN),
        .RBUF_DEPTH      (RBUF_DEPTH),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_credit (
        .clk              (clk),
        .reset            (reset),
        .issued           (rburst_issued),
        .issued_len       (rburst_issued_len),
        .rdata_last       (rdata_last),
        .buffer_pop       (buffer_pop),
        .len              (rburst_len),
        .credit_ok        (credit_ok),
        .outstanding      (outstanding),
        .outstanding_next (outstanding_next)
    );

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            IDLE: begin
                if (rd_req) begin
                    remaining_next = rd_req_beats;
                    state_next     = (rd_req_beats == '0) ? DRAIN : ISSUE;
                end
            end
            ISSUE: begin
                if (burst_ok) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (rburst_issued) begin
                    remaining_next = rem_after;
                    state_next     = (rem_after == '0) ? DRAIN : ISSUE;
                end
            end
            DRAIN: begin
                // Look at the post-update count so a final RLAST is seen at once.
                if (outstanding_next == '0) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
        end
    end

    // Strobes decode the state register, so they are glitch-free registered
    // outputs and rburst_ready lags the burst_ok decision by one cycle.
    assign rd_req_ready = (state_reg == IDLE);
    assign rburst_ready = (state_reg == READY);
    assign rd_done      = (state_reg == DONE);

`ifdef RBURST_STATS_EN
    logic [31:0] stall_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if ((state_reg == ISSUE) && (remaining_reg != '0) && !burst_ok
                     && (stall_count_reg != '1)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign stall_count = stall_count_reg;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_rburst_counter.sv
// ---------------------------------------------------------------------------
// tb_rburst_counter
// Two instances: dut_a (RBUF_DEPTH 256, MAX_OUTSTANDING 4) and
// dut_b (RBUF_DEPTH 16, MAX_OUTSTANDING 2). Expected burst lengths and the
// expected buffer credit at rd_done are queued by the stimulus; monitors pop
// and compare them whenever a burst handshake or rd_done appears.
// ---------------------------------------------------------------------------
module tb_rburst_counter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // dut_a signals
    logic        a_rd_req, a_rd_req_ready, a_rdy, a_iss, a_last, a_pop, a_done;
    logic [15:0] a_beats;
    logic [3:0]  a_len, a_iss_len;
    logic [2:0]  a_out;
    logic [31:0] a_stall;
    // dut_b signals
    logic        b_rd_req, b_rd_req_ready, b_rdy, b_iss, b_last, b_pop, b_done;
    logic [15:0] b_beats;
    logic [3:0]  b_len, b_iss_len;
    logic [1:0]  b_out;
    logic [31:0] b_stall;

    rburst_counter #(
        .TXN_LEN_W(16), .RBURST_LEN(4), .MAX_BURST_LEN(16),
        .RBUF_DEPTH(256), .MAX_OUTSTANDING(4)
    ) dut_a (
        .clk(clk), .reset(reset),
        .rd_req(a_rd_req), .rd_req_beats(a_beats), .rd_req_ready(a_rd_req_ready),
        .rburst_len(a_len), .rburst_ready(a_rdy),
        .rburst_issued(a_iss), .rburst_issued_len(a_iss_len),
        .rdata_last(a_last), .buffer_pop(a_pop),
        .outstanding(a_out), .rd_done(a_done), .stall_count(a_stall)
    );

    rburst_counter #(
        .TXN_LEN_W(16), .RBURST_LEN(4), .MAX_BURST_LEN(16),
        .RBUF_DEPTH(16), .MAX_OUTSTANDING(2)
    ) dut_b (
        .clk(clk), .reset(reset),
        .rd_req(b_rd_req), .rd_req_beats(b_beats), .rd_req_ready(b_rd_req_ready),
        .rburst_len(b_len), .rburst_ready(b_rdy),
        .rburst_issued(b_iss), .rburst_issued_len(b_iss_len),
        .rdata_last(b_last), .buffer_pop(b_pop),
        .outstanding(b_out), .rd_done(b_done), .stall_count(b_stall)
    );

    int vectors    = 0;
    int miscompares = 0;

    logic [3:0] a_len_q[$];
    logic [3:0] b_len_q[$];
    int         a_done_q[$];
    int         b_done_q[$];
    int a_hs = 0, b_hs = 0, a_dones = 0, b_dones = 0;
    bit a_auto = 1'b1, b_auto = 1'b1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int pick(input int sel);
        case (sel)
            0:       return a_hs;
            1:       return b_hs;
            2:       return a_dones;
            default: return b_dones;
        endcase
    endfunction

    // Bounded wait on a monitor counter; an expired budget is a miscompare.
    task automatic wait_count(input int sel, input int target, input string name);
        for (int i = 0; i < 300; i++) begin
            if (pick(sel) >= target) return;
            tick();
        end
        vectors++;
        miscompares++;
        $display("FAIL %s: timeout, count %0d, required %0d", name, pick(sel), target);
    endtask

    // Auto issuers: acknowledge READY in the cycle it is presented.
    initial begin
        a_iss = 1'b0; a_iss_len = '0;
        forever begin
            tick();
            if (a_auto) begin a_iss = a_rdy; a_iss_len = a_len; end
        end
    end
    initial begin
        b_iss = 1'b0; b_iss_len = '0;
        forever begin
            tick();
            if (b_auto) begin b_iss = b_rdy; b_iss_len = b_len; end
        end
    end

    // Monitors
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (a_rdy && a_iss) begin
                a_hs++;
                if (a_len_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL a_burst: got unexpected burst len %0d, required none", a_len);
                end else check("a_burst_len", 64'(a_len), 64'(a_len_q.pop_front()));
            end
            if (a_done) begin
                a_dones++;
                if (a_done_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL a_done: got unexpected rd_done, required none");
                end else begin
                    check("a_done_credit", 64'(dut_a.u_credit.credit_reg), 64'(a_done_q.pop_front()));
                    check("a_done_outstanding", 64'(a_out), 64'd0);
                end
            end
        end
    end
    initial forever begin
        @(negedge clk);
        if (!reset) begin
            if (b_rdy && b_iss) begin
                b_hs++;
                if (b_len_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL b_burst: got unexpected burst len %0d, required none", b_len);
                end else check("b_burst_len", 64'(b_len), 64'(b_len_q.pop_front()));
            end
            if (b_done) begin
                b_dones++;
                if (b_done_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL b_done: got unexpected rd_done, required none");
                end else begin
                    check("b_done_credit", 64'(dut_b.u_credit.credit_reg), 64'(b_done_q.pop_front()));
                    check("b_done_outstanding", 64'(b_out), 64'd0);
                end
            end
        end
    end

    initial begin
        logic [31:0] s0, s1;
        int exp_stall;
        a_rd_req = 0; a_beats = '0; a_last = 0; a_pop = 0;
        b_rd_req = 0; b_beats = '0; b_last = 0; b_pop = 0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_rd_req_ready", 64'(a_rd_req_ready), 64'd1);
        check("rst_rburst_ready", 64'(a_rdy), 64'd0);
        check("rst_rd_done", 64'(a_done), 64'd0);
        check("rst_outstanding", 64'(a_out), 64'd0);
        check("rst_rburst_len", 64'(a_len), 64'd0);
        check("rst_stall_count", 64'(a_stall), 64'd0);
        check("rst_credit_a", 64'(dut_a.u_credit.credit_reg), 64'd256);
        check("rst_credit_b", 64'(dut_b.u_credit.credit_reg), 64'd16);

        // 40 beats -> bursts 15, 15, 7; credit 256-40 = 216 at done
        tick();
        a_len_q.push_back(4'd15); a_len_q.push_back(4'd15); a_len_q.push_back(4'd7);
        a_done_q.push_back(216);
        a_rd_req = 1; a_beats = 16'd40;
        tick();
        a_rd_req = 0;
        wait_count(0, 3, "t1_bursts");
        check("t1_outstanding", 64'(a_out), 64'd3);
        a_last = 1; repeat (3) tick(); a_last = 0;
        wait_count(2, 1, "t1_done");
        repeat (3) tick();
        check("t1_done_count", 64'(a_dones), 64'd1);

        // Handshakes outside READY: credit 216 -> 100 with outstanding 1
        a_auto = 0; a_iss = 0;
        a_iss = 1; a_iss_len = 4'd15; tick();
        a_last = 1; repeat (6) tick();
        a_iss_len = 4'd3; tick();
        a_iss = 0; a_last = 0;
        check("t4_credit_pre", 64'(dut_a.u_credit.credit_reg), 64'd100);
        check("t4_outstanding_pre", 64'(a_out), 64'd1);
        check("t4_fsm_ignores", 64'(a_rd_req_ready), 64'd1);
        // issue(16) + pop + last together: 100 - 16 + 1 = 85, outstanding 1
        a_iss = 1; a_iss_len = 4'd15; a_pop = 1; a_last = 1; tick();
        a_iss = 0; a_pop = 0; a_last = 0;
        check("t4_credit", 64'(dut_a.u_credit.credit_reg), 64'd85);
        check("t4_outstanding", 64'(a_out), 64'd1);
        a_last = 1; tick();
        check("t4_out_dec", 64'(a_out), 64'd0);
        tick(); a_last = 0;
        check("t4_out_floor", 64'(a_out), 64'd0);
        a_auto = 1;
        tick();

        // Zero-beat transfer: DRAIN then DONE, second rd_req ignored
        a_done_q.push_back(85);
        a_rd_req = 1; a_beats = 16'd0; tick();
        check("t5_req_ready_drain", 64'(a_rd_req_ready), 64'd0);
        a_beats = 16'd5; tick();
        a_rd_req = 0;
        check("t5_done_pulse", 64'(a_done), 64'd1);
        tick();
        check("t5_done_clear", 64'(a_done), 64'd0);
        check("t5_idle", 64'(a_rd_req_ready), 64'd1);
        check("t5_ignored_req_len", 64'(a_len), 64'd0);
        repeat (4) tick();
        check("t5_no_bursts", 64'(a_hs), 64'd3);
        check("t5_done_count", 64'(a_dones), 64'd2);

        // dut_b: credit stall, then outstanding stall
        b_len_q.push_back(4'd15);
        b_rd_req = 1; b_beats = 16'd48; tick();
        b_rd_req = 0;
        wait_count(1, 1, "b_first_burst");
        @(negedge clk);
        s0 = b_stall;
        for (int i = 0; i < 20; i++) begin
            tick();
            b_pop = ((i % 4) != 3);
        end
        @(negedge clk);
        s1 = b_stall;
`ifdef RBURST_STATS_EN
        exp_stall = 20;
`else
        exp_stall = 0;
        check("b_stall_tied", 64'(b_stall), 64'd0);
`endif
        check("b_stall_delta", 64'(s1 - s0), 64'(exp_stall));
        check("b_credit_stall_ready", 64'(b_rdy), 64'd0);
        check("b_credit_stall_hs", 64'(b_hs), 64'd1);
        tick();
        b_len_q.push_back(4'd15);
        b_pop = 1; tick(); b_pop = 0;
        wait_count(1, 2, "b_second_burst");
        repeat (16) begin b_pop = 1; tick(); end
        b_pop = 0;
        repeat (4) tick();
        check("b_out_stall_ready", 64'(b_rdy), 64'd0);
        check("b_out_stall_out", 64'(b_out), 64'd2);
        check("b_out_stall_credit", 64'(dut_b.u_credit.credit_reg), 64'd16);
        check("b_out_stall_hs", 64'(b_hs), 64'd2);
        b_len_q.push_back(4'd15);
        b_done_q.push_back(0);
        b_last = 1; tick(); b_last = 0;
        wait_count(1, 3, "b_third_burst");
        check("b_out_after_third", 64'(b_out), 64'd2);
        b_last = 1; repeat (2) tick(); b_last = 0;
        wait_count(3, 1, "b_done");

        // Reset mid-transfer: no rd_done, all state back to reset values
        a_len_q.push_back(4'd15);
        a_rd_req = 1; a_beats = 16'd40; tick();
        a_rd_req = 0;
        wait_count(0, 4, "abort_first_burst");
        reset = 1;
        a_len_q.delete(); a_done_q.delete(); b_len_q.delete(); b_done_q.delete();
        repeat (2) tick();
        reset = 0;
        repeat (6) tick();
        check("abort_no_done", 64'(a_dones), 64'd2);
        check("abort_req_ready", 64'(a_rd_req_ready), 64'd1);
        check("abort_outstanding", 64'(a_out), 64'd0);
        check("abort_credit", 64'(dut_a.u_credit.credit_reg), 64'd256);
        check("abort_stall_b", 64'(b_stall), 64'd0);
        a_pop = 1; tick(); a_pop = 0;
        check("pop_at_full", 64'(dut_a.u_credit.credit_reg), 64'd256);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
